// File: rtl/pdes_pkg.sv
// pdes_pkg: shared PDES sizing constants and timestamp type
package pdes_pkg;
  localparam int NUM_CORE = 8;
  localparam int TIME_WID = 16;
  localparam int CORE_WID = $clog2(NUM_CORE);
  typedef logic [TIME_WID-1:0] time_t;
endpackage

// File: rtl/lowest_zero_enc.sv
// lowest_zero_enc: index of the lowest clear bit plus an any-clear flag
module lowest_zero_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any_zero
);
  always_comb begin
    idx = '0;
    any_zero = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (!vec[i]) begin
        idx = W'(i);
        any_zero = 1'b1;
      end
  end
endmodule

// File: rtl/core_time_tracker.sv
// core_time_tracker: per-core busy flags and in-flight event timestamps for GVT
module core_time_tracker #(
  parameter int NUM_CORE = pdes_pkg::NUM_CORE,
  parameter int TIME_WID = pdes_pkg::TIME_WID,
  parameter int CORE_WID = $clog2(NUM_CORE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         disp_vld,
  input  logic [TIME_WID-1:0]          disp_time,
  output logic                         disp_rdy,
  output logic [CORE_WID-1:0]          disp_core,
  input  logic [NUM_CORE-1:0]          core_done,
  output logic [TIME_WID*NUM_CORE-1:0] core_times,
  output logic [NUM_CORE-1:0]          core_vld,
  output logic [CORE_WID:0]            busy_cnt,
  output logic                         all_idle,
  output logic                         err_done
);
  logic                         any_free;
  logic                         hs;
  logic [NUM_CORE-1:0]          retire;
  logic [NUM_CORE-1:0]          vld_nxt;
  logic [TIME_WID*NUM_CORE-1:0] times_nxt;
  logic [CORE_WID:0]            ret_cnt;

  lowest_zero_enc #(.N(NUM_CORE), .W(CORE_WID)) u_enc (
    .vec     (core_vld),
    .idx     (disp_core),
    .any_zero(any_free)
  );

  assign disp_rdy = rst_n && any_free;
  assign hs       = disp_vld && disp_rdy;
  assign retire   = core_done & core_vld;
  assign all_idle = ~|core_vld;

  // dispatch target is idle, so it never collides with a valid retire
  always_comb begin
    vld_nxt = core_vld & ~retire;
    times_nxt = core_times;
    ret_cnt = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      if (retire[i]) times_nxt[TIME_WID*i +: TIME_WID] = '0;
      ret_cnt = ret_cnt + (CORE_WID+1)'(retire[i]);
    end
    if (hs) begin
      vld_nxt[disp_core] = 1'b1;
      times_nxt[TIME_WID*int'(disp_core) +: TIME_WID] = disp_time;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      core_vld   <= '0;
      core_times <= '0;
      busy_cnt   <= '0;
      err_done   <= 1'b0;
    end else begin
      core_vld   <= vld_nxt;
      core_times <= times_nxt;
      busy_cnt   <= busy_cnt + (CORE_WID+1)'(hs) - ret_cnt;
      err_done   <= err_done | (|(core_done & ~core_vld));
    end
endmodule

// File: tb/tb_core_time_tracker.sv
// tb_core_time_tracker: scoreboard bench with a slot-array reference model
module tb_core_time_tracker;
  localparam int N  = pdes_pkg::NUM_CORE;
  localparam int TW = pdes_pkg::TIME_WID;
  localparam int CW = $clog2(N);
  localparam int XW = TW * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_vld = 1'b0;
  logic [TW-1:0] disp_time = '0;
  logic [N-1:0]  core_done = '0;
  logic          disp_rdy;
  logic [CW-1:0] disp_core;
  logic [XW-1:0] core_times;
  logic [N-1:0]  core_vld;
  logic [CW:0]   busy_cnt;
  logic          all_idle;
  logic          err_done;

  core_time_tracker dut (
    .clk(clk), .rst_n(rst_n), .disp_vld(disp_vld), .disp_time(disp_time),
    .disp_rdy(disp_rdy), .disp_core(disp_core), .core_done(core_done),
    .core_times(core_times), .core_vld(core_vld), .busy_cnt(busy_cnt),
    .all_idle(all_idle), .err_done(err_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  vld;
    logic [XW-1:0] times;
    int            cnt;
    bit            err;
    bit            rdy;
    int            core;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total = 0;
  bit   m_busy[N];
  int   m_time[N];
  bit   m_err;

  function automatic void chk(string nm, logic [XW-1:0] act, logic [XW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic int lowest_idle();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.vld = '0; e.times = '0; e.cnt = 0;
    for (int i = 0; i < N; i++) begin
      e.vld[i] = m_busy[i];
      e.times[TW*i +: TW] = TW'(m_time[i]);
      e.cnt += int'(m_busy[i]);
    end
    e.err = m_err;
    e.core = lowest_idle();
    e.rdy = e.core >= 0;
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_time[i] = 0; end
    m_err = 0;
  endfunction

  function automatic logic [N-1:0] busy_mask();
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = m_busy[i];
    return m;
  endfunction

  // one clock of stimulus; the model applies the same cycle's rules and queues the outcome
  task automatic step(input bit v, input logic [TW-1:0] t, input logic [N-1:0] d);
    int k;
    @(negedge clk);
    #1;
    disp_vld = v; disp_time = t; core_done = d;
    k = lowest_idle();
    if (v && k >= 0) chk("disp_core_hs", disp_core, k);
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (d[i]) begin
        if (m_busy[i]) begin m_busy[i] = 0; m_time[i] = 0; end
        else m_err = 1;
      end
    if (v && k >= 0) begin m_busy[k] = 1; m_time[k] = int'(t); end
    q.push_back(snap());
    #1;
    disp_vld = 1'b0; core_done = '0;
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_vld", core_vld, e.vld);
      chk("sb_times", core_times, e.times);
      chk("sb_cnt", busy_cnt, e.cnt);
      chk("sb_err", err_done, e.err);
      chk("sb_idle", all_idle, e.vld == 0);
      chk("sb_rdy", disp_rdy, e.rdy);
      if (e.rdy) chk("sb_core", disp_core, e.core);
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach end");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(string nm);
    chk({nm, "_vld"}, core_vld, 0);
    chk({nm, "_times"}, core_times, 0);
    chk({nm, "_cnt"}, busy_cnt, 0);
    chk({nm, "_idle"}, all_idle, 1);
    chk({nm, "_rdy"}, disp_rdy, 0);
    chk({nm, "_err"}, err_done, 0);
  endtask

  initial begin
    logic [N-1:0] d;
    int wait_cyc;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("rst");
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy_after", disp_rdy, 1);
    chk("rst_core_after", disp_core, 0);

    step(1, 16'h25, '0);
    chk("single_vld", core_vld, 8'h01);
    chk("single_slot0", core_times[15:0], 16'h25);
    chk("single_cnt", busy_cnt, 1);
    step(0, '0, 8'h01);

    for (int i = 0; i < 8; i++) step(1, TW'(16'h10 + i), '0);
    chk("fill_vld", core_vld, 8'hFF);
    chk("fill_rdy", disp_rdy, 0);
    chk("fill_cnt", busy_cnt, 8);
    for (int i = 0; i < 8; i++) chk("fill_slot", core_times[TW*i +: TW], TW'(16'h10 + i));

    step(0, '0, 8'h24);
    chk("retire_vld", core_vld, 8'hDB);
    chk("retire_cnt", busy_cnt, 6);
    chk("retire_core", disp_core, 2);
    step(1, 16'h30, '0);
    chk("redisp_slot2", core_times[47:32], 16'h30);
    chk("redisp_vld", core_vld, 8'hDF);

    step(1, 16'h35, '0);
    step(0, '0, 8'h80);
    chk("pre_same_vld", core_vld, 8'h7F);
    step(1, 16'h40, 8'h01);
    chk("same_vld", core_vld, 8'hFE);
    chk("same_cnt", busy_cnt, 7);
    chk("same_slot7", core_times[127:112], 16'h40);

    for (int c = 0; c < 400; c++) begin
      d = N'($urandom) & busy_mask() & N'($urandom);
      if ($urandom_range(19) == 0) d[$urandom_range(N-1)] = 1'b1;
      step(($urandom_range(3) != 0), TW'($urandom), d);
    end
    step(0, '0, busy_mask());

    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("rand_rst");
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1, TW'(16'h50 + i), '0);
    step(0, '0, 8'h20);
    chk("spur_err", err_done, 1);
    chk("spur_vld", core_vld, 8'h07);
    step(1, 16'h60, '0);
    step(0, '0, '0);
    chk("spur_sticky", err_done, 1);
    chk("spur_vld2", core_vld, 8'h0F);

    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    #1 rst_n = 1'b1;

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/core_time_tracker.md
# core_time_tracker

Tracks which simulation cores are busy and the timestamp of the event each busy core is processing. It accepts event dispatches from the event queue, picks the lowest-index idle core, and retires cores on completion. It drives the registered `core_times`/`core_vld` vectors that feed `gvt_monitor` directly, so its state must always reflect every in-flight event.

## Interface
- `NUM_CORE`, default 8: number of simulation cores; power of two, at least 2.
- `TIME_WID`, default 16: timestamp width.
- `CORE_WID`, default `$clog2(NUM_CORE)`: core index width.

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; the reset is asynchronous and active-low.
- `disp_vld`  in  1  event queue offers an event for dispatch.
- `disp_time`  in  TIME_WID  timestamp of the offered event.
- `disp_rdy`  out  1  at least one core idle; dispatch accepted when `disp_vld && disp_rdy`.
- `disp_core`  out  CORE_WID  core that receives the event on handshake; lowest-index idle core.
- `core_done`  in  NUM_CORE  per-core one-cycle completion pulse.
- `core_times`  out  TIME_WID*NUM_CORE  per-core event timestamp; slot i is `[TIME_WID*i +: TIME_WID]`.
- `core_vld`  out  NUM_CORE  core i is busy and slot i is meaningful.
- `busy_cnt`  out  CORE_WID+1  number of busy cores (popcount of `core_vld`).
- `all_idle`  out  1  `core_vld == 0`.
- `err_done`  out  1  sticky flag: a `core_done` arrived for an idle core.

## Operation
- State is the registers `core_vld`, `core_times`, `busy_cnt` and `err_done`.
- `disp_core` is the priority-encoded lowest index with `core_vld[i]==0`. It is combinational from the current registered `core_vld`.
- `disp_rdy = rst_n && (core_vld != all-ones)`. When all cores are busy, `disp_rdy` is 0 and `disp_core` is don't-care.
- Handshake at edge: sets `core_vld[disp_core]=1` and `core_times[disp_core]=disp_time`.
- `core_done[i]` with `core_vld[i]==1` clears `core_vld[i]` and zeroes `core_times` slot i.
- `core_done[i]` with `core_vld[i]==0` is ignored for state and sets `err_done`. `err_done` clears only on reset.
- Multiple `core_done` bits may be set in one cycle; all are retired together.
- Done and dispatch in the same cycle:
  - `disp_core` is computed from pre-retire state, so a core freed this cycle is not reused until the next cycle.
  - The handshake and the retire never target the same core, because the dispatch target is idle and has no valid done.
- `busy_cnt` at each edge = old count + handshake − number of valid retires. It is registered together with `core_vld` and always equals `popcount(core_vld)`.
- `disp_time` is stored unmodified; no wrap or ordering checks are made.

## Timing
- Reset (async assert, sync release is not required):
  - `core_vld=0`, `core_times=0`, `busy_cnt=0`, `err_done=0`.
  - `all_idle=1`, `disp_rdy=0` while `rst_n` is low.
- Dispatch latency: slot visible on `core_vld`/`core_times` 1 cycle after the handshake edge.
- The event queue pops the dispatched event at the same edge. This makes the event pass from `next_event` to `core_times` with no cycle in which `gvt_monitor` misses it.
- Retire latency: `core_vld[i]` falls 1 cycle after the `core_done[i]` edge.
- Back-to-back dispatch at 1 per cycle is sustained while idle cores remain.
- Reset mid-operation: all in-flight entries are dropped immediately; no completion is required.

## Structure
- Shared package `pdes_pkg`: `TIME_WID`, `NUM_CORE`, `CORE_WID` constants and the `time_t` typedef, shared with `gvt_monitor`.
- One sub-module, `lowest_zero_enc`: parameterised priority encoder returning the lowest-zero index and an any-zero flag. It drives `disp_core` and `disp_rdy`.
- Retire logic, popcount update and the error flag are inline.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles, then release. Required: `core_vld=0`, `busy_cnt=0`, `all_idle=1`, `disp_rdy` 0 during reset and 1 after.
- **Single dispatch:** dispatch `disp_time=16'h25`. Required: `disp_core=0`, and next cycle `core_vld=8'h01`, slot0=`16'h25`, `busy_cnt=1`.
- **Fill all cores:** 8 back-to-back dispatches with times `16'h10`..`16'h17`. Required: `disp_core` 0..7 in order, `core_vld=8'hFF`, `disp_rdy=0`, `busy_cnt=8`, slot i=`16'h10+i`.
- **Simultaneous retire and dispatch:** with all cores full, pulse `core_done=8'h24`, then next cycle dispatch `16'h30`. Required: `core_vld=8'hDB`, `busy_cnt=6`, `disp_core=2`; after dispatch, slot2=`16'h30` and `core_vld=8'hDF`.
- **Same-cycle retire and dispatch:** with `core_vld=8'h7F`, assert `core_done[0]` together with dispatch of `16'h40`. Required: the event goes to core 7, and next cycle `core_vld=8'hFE`, `busy_cnt=7`.
- **Spurious done and mid-operation reset:**
  - Pulse `core_done[5]` while core 5 is idle. Required: `err_done=1` and stays 1, with `core_vld` unchanged.
  - Then assert `rst_n=0` mid-run. Required: all outputs return to their reset values asynchronously.
